edge_fetch_ctrl: RTL and testbench
==================================

EDGE_FETCH_CTRL -- requirements
Module: edge_fetch_ctrl

Interface
REQ-001 Parameter NODE_IDX_WIDTH, default 10: node index width, matches the path-counting core.
REQ-002 Parameter COUNTER_WIDTH, default 4: per-node edge count width; max 15 edges.
REQ-003 Parameter ADDR_WIDTH, default 12: edge-list memory address width.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  core requests the edges of a node.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_node_idx  in  NODE_IDX_WIDTH  node whose edges are fetched.
REQ-010 abort  in  1  synchronous cancel of the current fetch.
REQ-011 hdr_rd_en / hdr_rd_addr  out  1 / NODE_IDX_WIDTH  header memory read strobe and address.
REQ-012 hdr_rd_base / hdr_rd_count  in  ADDR_WIDTH / COUNTER_WIDTH  header data, valid one cycle after hdr_rd_en.
REQ-013 edge_rd_en / edge_rd_addr  out  1 / ADDR_WIDTH  edge memory read strobe and address.
REQ-014 edge_rd_data  in  NODE_IDX_WIDTH  successor index, valid one cycle after edge_rd_en.
REQ-015 edge_valid / edge_ready  out / in  1 / 1  successor stream handshake.
REQ-016 edge_node_idx  out  NODE_IDX_WIDTH  registered successor index.
REQ-017 edge_last  out  1  high with the final edge of the node.
REQ-018 leaf  out  1  one-cycle pulse: node has zero edges.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 stat_edges  out  16  edge-handshake statistic (see Configuration).

Function
REQ-021 FSM states: IDLE, HDR_REQ, HDR_CAP, EDGE_REQ, EDGE_CAP, EDGE_OUT.
REQ-022 IDLE: req_ready=1; on req_valid, latch req_node_idx, go HDR_REQ; other states req_ready=0.
REQ-023 HDR_REQ: hdr_rd_en=1, hdr_rd_addr=latched index; go HDR_CAP.
REQ-024 HDR_CAP: capture base and count, clear edge counter k; count==0 -> leaf=1 this cycle, go IDLE; else go EDGE_REQ.
REQ-025 EDGE_REQ: edge_rd_en=1, edge_rd_addr=(base+k) mod 2^ADDR_WIDTH; go EDGE_CAP.
REQ-026 EDGE_CAP: register edge_rd_data into edge_node_idx, edge_last=(k==count-1); go EDGE_OUT.
REQ-027 EDGE_OUT: edge_valid=1; edge_node_idx and edge_last stable until edge_ready; on handshake, last -> IDLE, else k+1 and EDGE_REQ.
REQ-028 Latency: request handshake in cycle N -> first edge_valid in cycle N+5; with edge_ready tied high, one edge per 3 cycles.
REQ-029 Memory strobes are single-cycle; at most one outstanding read per memory.
REQ-030 abort in any state: next state IDLE; edge_valid, leaf, rd strobes low from next cycle; a request coincident with abort in IDLE is not accepted.
REQ-031 edge_valid, edge_last, leaf, hdr_rd_en, edge_rd_en low whenever not in their named state.

Reset
REQ-032 On rst: state IDLE, all outputs 0 except req_ready=1; latched index, base, count, k, edge_node_idx = 0.
REQ-033 rst mid-fetch discards the fetch; no edge_valid or leaf until a new request.

Configuration
REQ-034 Macro EDGE_FETCH_STATS_EN defined: stat_edges counts edge handshakes, saturates at 16'hFFFF, cleared only by rst.
REQ-035 Macro undefined: stat_edges tied to 0, no counter flops.

Structure
REQ-036 Package edge_fetch_pkg: FSM state enum (3-bit) and default width constants.
REQ-037 No sub-module; single flat module.

Verification
REQ-038 Node 5, header base=0x010 count=3, edges 7,9,12, edge_ready=1 -> edge_valid at N+5, N+8, N+11 with 7,9,12; edge_last only on 12; edge_rd_addr 0x010,0x011,0x012.
REQ-039 Node 3, count=0 -> leaf pulse in HDR_CAP cycle, no edge_rd_en, back in IDLE with req_ready=1 next cycle.
REQ-040 count=2, edge_ready low 4 cycles on first edge -> edge_node_idx/edge_valid held stable, second edge follows after release.
REQ-041 base=0xFFF count=2 -> edge_rd_addr 0xFFF then 0x000.
REQ-042 abort asserted in EDGE_OUT of edge 1 of 3 -> IDLE next cycle, edge_valid low, no further reads; rst asserted in EDGE_CAP -> all outputs at reset values immediately.
REQ-043 With EDGE_FETCH_STATS_EN, 3+2 edges streamed -> stat_edges=5; without macro -> stat_edges=0.

Source files
------------

// File: rtl/edge_fetch_pkg.sv
// Edge fetch controller package: FSM state encoding and default widths.
package edge_fetch_pkg;

    localparam int DEF_NODE_IDX_WIDTH = 10;
    localparam int DEF_COUNTER_WIDTH  = 4;
    localparam int DEF_ADDR_WIDTH     = 12;
    localparam int STAT_WIDTH         = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_REQ  = 3'd1,
        ST_HDR_CAP  = 3'd2,
        ST_EDGE_REQ = 3'd3,
        ST_EDGE_CAP = 3'd4,
        ST_EDGE_OUT = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/edge_fetch_ctrl.sv
// Edge fetch controller: reads a node header (base, count) and then streams
// the node's successor indices one at a time over a valid/ready handshake.
// Optional feature: define EDGE_FETCH_STATS_EN to get a saturating count of
// edge handshakes on stat_edges; otherwise stat_edges is tied to zero.
module edge_fetch_ctrl
    import edge_fetch_pkg::*;
#(
    parameter int NODE_IDX_WIDTH = DEF_NODE_IDX_WIDTH,
    parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [NODE_IDX_WIDTH-1:0] req_node_idx,
    input  logic                      abort,
    output logic                      hdr_rd_en,
    output logic [NODE_IDX_WIDTH-1:0] hdr_rd_addr,
    input  logic [ADDR_WIDTH-1:0]     hdr_rd_base,
    input  logic [COUNTER_WIDTH-1:0]  hdr_rd_count,
    output logic                      edge_rd_en,
    output logic [ADDR_WIDTH-1:0]     edge_rd_addr,
    input  logic [NODE_IDX_WIDTH-1:0] edge_rd_data,
    output logic                      edge_valid,
    input  logic                      edge_ready,
    output logic [NODE_IDX_WIDTH-1:0] edge_node_idx,
    output logic                      edge_last,
    output logic                      leaf,
    output logic                      busy,
    output logic [STAT_WIDTH-1:0]     stat_edges
);

    fetch_state_e             state_q, state_d;
    logic [NODE_IDX_WIDTH-1:0] node_q;
    logic [ADDR_WIDTH-1:0]     base_q;
    logic [COUNTER_WIDTH-1:0]  count_q;
    logic [COUNTER_WIDTH-1:0]  k_q;
    logic                      last_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and strobe decode; abort overrides every transition
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        hdr_rd_en  = 1'b0;
        edge_rd_en = 1'b0;
        edge_valid = 1'b0;
        leaf       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !abort) state_d = ST_HDR_REQ;
            end
            ST_HDR_REQ: begin
                hdr_rd_en = 1'b1;
                state_d   = ST_HDR_CAP;
            end
            ST_HDR_CAP: begin
                // header data is on the bus this cycle, so a leaf is flagged directly from it
                if (hdr_rd_count == '0) begin
                    leaf    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EDGE_REQ;
                end
            end
            ST_EDGE_REQ: begin
                edge_rd_en = 1'b1;
                state_d    = ST_EDGE_CAP;
            end
            ST_EDGE_CAP: begin
                state_d = ST_EDGE_OUT;
            end
            ST_EDGE_OUT: begin
                edge_valid = 1'b1;
                if (edge_ready) state_d = last_q ? ST_IDLE : ST_EDGE_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Request, header and edge-counter datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_q        <= '0;
            base_q        <= '0;
            count_q       <= '0;
            k_q           <= '0;
            edge_node_idx <= '0;
            last_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && !abort) node_q <= req_node_idx;
                end
                ST_HDR_CAP: begin
                    base_q  <= hdr_rd_base;
                    count_q <= hdr_rd_count;
                    k_q     <= '0;
                end
                ST_EDGE_CAP: begin
                    edge_node_idx <= edge_rd_data;
                    last_q        <= (k_q == count_q - 1'b1);
                end
                ST_EDGE_OUT: begin
                    if (edge_ready && !last_q && !abort) k_q <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign hdr_rd_addr  = node_q;
    // address wraps modulo the edge memory size
    assign edge_rd_addr = base_q + ADDR_WIDTH'(k_q);
    assign edge_last    = (state_q == ST_EDGE_OUT) && last_q;

`ifdef EDGE_FETCH_STATS_EN
    logic [STAT_WIDTH-1:0] stat_q;

    // Saturating count of edge handshakes, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stat_q <= '0;
        else if (edge_valid && edge_ready && (stat_q != '1))
            stat_q <= stat_q + 1'b1;
    end

    assign stat_edges = stat_q;
`else
    assign stat_edges = '0;
`endif

endmodule

// File: tb/tb_edge_fetch_ctrl.sv
// Self-checking bench for edge_fetch_ctrl with header/edge memory models.
module tb_edge_fetch_ctrl;

    localparam int NW = 10;
    localparam int CW = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [NW-1:0] req_node_idx;
    logic          abort;
    logic          hdr_rd_en;
    logic [NW-1:0] hdr_rd_addr;
    logic [AW-1:0] hdr_rd_base;
    logic [CW-1:0] hdr_rd_count;
    logic          edge_rd_en;
    logic [AW-1:0] edge_rd_addr;
    logic [NW-1:0] edge_rd_data;
    logic          edge_valid;
    logic          edge_ready;
    logic [NW-1:0] edge_node_idx;
    logic          edge_last;
    logic          leaf;
    logic          busy;
    logic [15:0]   stat_edges;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // scoreboard queues
    logic [NW-1:0] idx_q[$];
    logic          lst_q[$];
    int            vcyc_q[$];
    logic [AW-1:0] addr_q[$];

    logic [AW-1:0] hb_mem [0:(1<<NW)-1];
    logic [CW-1:0] hc_mem [0:(1<<NW)-1];
    logic [NW-1:0] e_mem  [0:(1<<AW)-1];

    edge_fetch_ctrl #(
        .NODE_IDX_WIDTH(NW),
        .COUNTER_WIDTH (CW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_node_idx (req_node_idx),
        .abort        (abort),
        .hdr_rd_en    (hdr_rd_en),
        .hdr_rd_addr  (hdr_rd_addr),
        .hdr_rd_base  (hdr_rd_base),
        .hdr_rd_count (hdr_rd_count),
        .edge_rd_en   (edge_rd_en),
        .edge_rd_addr (edge_rd_addr),
        .edge_rd_data (edge_rd_data),
        .edge_valid   (edge_valid),
        .edge_ready   (edge_ready),
        .edge_node_idx(edge_node_idx),
        .edge_last    (edge_last),
        .leaf         (leaf),
        .busy         (busy),
        .stat_edges   (stat_edges)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: data valid one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (hdr_rd_en) begin
            hdr_rd_base  <= hb_mem[hdr_rd_addr];
            hdr_rd_count <= hc_mem[hdr_rd_addr];
        end else begin
            hdr_rd_base  <= 12'hAAA;
            hdr_rd_count <= 4'hF;
        end
        if (edge_rd_en) edge_rd_data <= e_mem[edge_rd_addr];
        else            edge_rd_data <= 10'h3FF;
    end

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_node_idx = '0; abort = 1'b0; edge_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, busy, hdr_rd_en, edge_rd_en, edge_valid, edge_last, leaf} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {req_ready, busy, hdr_rd_en, edge_rd_en, edge_valid, edge_last, leaf});
        end
        checks++;
        if (edge_node_idx !== '0 || hdr_rd_addr !== '0 || edge_rd_addr !== '0 || stat_edges !== '0) begin
            failures++;
            $display("FAIL reset_data: got idx=%0h haddr=%0h eaddr=%0h stat=%0h expected all 0",
                     edge_node_idx, hdr_rd_addr, edge_rd_addr, stat_edges);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got ready=%b busy=%b expected ready=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        int c0;
        logic [AW-1:0] ea;
        hb_mem[5] = 12'h010; hc_mem[5] = 4'd3;
        e_mem[12'h010] = 10'd7; e_mem[12'h011] = 10'd9; e_mem[12'h012] = 10'd12;
        edge_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_req_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_node_idx = 10'd5; c0 = cyc;
        idx_q.push_back(10'd7);  lst_q.push_back(1'b0); vcyc_q.push_back(c0 + 5);
        idx_q.push_back(10'd9);  lst_q.push_back(1'b0); vcyc_q.push_back(c0 + 8);
        idx_q.push_back(10'd12); lst_q.push_back(1'b1); vcyc_q.push_back(c0 + 11);
        addr_q.push_back(12'h010); addr_q.push_back(12'h011); addr_q.push_back(12'h012);
        @(negedge clk);
        req_valid = 1'b0; req_node_idx = 10'd33;
        for (int i = 0; i < 20; i++) begin
            if (hdr_rd_en) begin
                checks++;
                if (hdr_rd_addr !== 10'd5 || cyc != c0 + 1) begin
                    failures++;
                    $display("FAIL basic_hdr: got addr=%0d cyc=%0d expected addr=5 cyc=%0d", hdr_rd_addr, cyc, c0 + 1);
                end
            end
            if (edge_rd_en) begin
                checks++;
                ea = '1;
                if (addr_q.size() > 0) ea = addr_q.pop_front();
                if (edge_rd_addr !== ea) begin
                    failures++;
                    $display("FAIL basic_edge_addr: got %0h expected %0h", edge_rd_addr, ea);
                end
            end
            if (edge_valid && idx_q.size() > 0) begin
                logic [NW-1:0] ei;
                logic          el;
                int            ec;
                ei = idx_q.pop_front(); el = lst_q.pop_front(); ec = vcyc_q.pop_front();
                checks++;
                if (edge_node_idx !== ei || edge_last !== el || cyc != ec) begin
                    failures++;
                    $display("FAIL basic_edge: got idx=%0d last=%b cyc=%0d expected idx=%0d last=%b cyc=%0d",
                             edge_node_idx, edge_last, cyc, ei, el, ec);
                end
            end
            if (leaf) begin
                checks++; failures++;
                $display("FAIL basic_leaf: got 1 expected 0");
            end
            if (idx_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (idx_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL basic_timeout: got %0d edges pending expected 0", idx_q.size());
            idx_q.delete(); lst_q.delete(); vcyc_q.delete(); addr_q.delete();
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || edge_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_end_idle: got busy=%b ready=%b valid=%b expected 0 1 0", busy, req_ready, edge_valid);
        end
    endtask

    task automatic test_backpressure();
        int c0;
        int k;
        hb_mem[8] = 12'h100; hc_mem[8] = 4'd2;
        e_mem[12'h100] = 10'd21; e_mem[12'h101] = 10'd22;
        edge_ready = 1'b0;
        idx_q.push_back(10'd21); lst_q.push_back(1'b0);
        idx_q.push_back(10'd22); lst_q.push_back(1'b1);
        addr_q.push_back(12'h101);
        req_valid = 1'b1; req_node_idx = 10'd8; c0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!edge_valid && k < 10) begin @(negedge clk); k++; end
        checks++;
        if (edge_valid !== 1'b1 || cyc != c0 + 5 || edge_node_idx !== idx_q[0] || edge_last !== lst_q[0]) begin
            failures++;
            $display("FAIL bp_first: got valid=%b cyc=%0d idx=%0d last=%b expected 1 %0d %0d %b",
                     edge_valid, cyc, edge_node_idx, edge_last, c0 + 5, idx_q[0], lst_q[0]);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (edge_valid !== 1'b1 || edge_node_idx !== idx_q[0] || edge_last !== lst_q[0]) begin
                failures++;
                $display("FAIL bp_hold: got valid=%b idx=%0d last=%b expected 1 %0d %b",
                         edge_valid, edge_node_idx, edge_last, idx_q[0], lst_q[0]);
            end
        end
        void'(idx_q.pop_front()); void'(lst_q.pop_front());
        edge_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk); k++;
            if (edge_rd_en) begin
                logic [AW-1:0] ea;
                ea = '1;
                if (addr_q.size() > 0) ea = addr_q.pop_front();
                checks++;
                if (edge_rd_addr !== ea) begin
                    failures++;
                    $display("FAIL bp_addr: got %0h expected %0h", edge_rd_addr, ea);
                end
            end
        end while (!edge_valid && k < 10);
        checks++;
        if (edge_valid !== 1'b1 || cyc != c0 + 12 || edge_node_idx !== idx_q[0] || edge_last !== lst_q[0]) begin
            failures++;
            $display("FAIL bp_second: got valid=%b cyc=%0d idx=%0d last=%b expected 1 %0d %0d %b",
                     edge_valid, cyc, edge_node_idx, edge_last, c0 + 12, idx_q[0], lst_q[0]);
        end
        idx_q.delete(); lst_q.delete(); addr_q.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_end_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_stats();
        logic [15:0] exp_stat;
`ifdef EDGE_FETCH_STATS_EN
        exp_stat = 16'd5;
`else
        exp_stat = 16'd0;
`endif
        checks++;
        if (stat_edges !== exp_stat) begin
            failures++;
            $display("FAIL stat_edges: got %0d expected %0d", stat_edges, exp_stat);
        end
    endtask

    task automatic test_wrap();
        int c0;
        hb_mem[9] = 12'hFFF; hc_mem[9] = 4'd2;
        e_mem[12'hFFF] = 10'd100; e_mem[12'h000] = 10'd101;
        edge_ready = 1'b1;
        addr_q.push_back(12'hFFF); addr_q.push_back(12'h000);
        idx_q.push_back(10'd100); lst_q.push_back(1'b0);
        idx_q.push_back(10'd101); lst_q.push_back(1'b1);
        req_valid = 1'b1; req_node_idx = 10'd9; c0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (edge_rd_en) begin
                logic [AW-1:0] ea;
                ea = '1;
                if (addr_q.size() > 0) ea = addr_q.pop_front();
                checks++;
                if (edge_rd_addr !== ea) begin
                    failures++;
                    $display("FAIL wrap_addr: got %0h expected %0h", edge_rd_addr, ea);
                end
            end
            if (edge_valid && idx_q.size() > 0) begin
                logic [NW-1:0] ei;
                logic          el;
                ei = idx_q.pop_front(); el = lst_q.pop_front();
                checks++;
                if (edge_node_idx !== ei || edge_last !== el) begin
                    failures++;
                    $display("FAIL wrap_edge: got idx=%0d last=%b expected idx=%0d last=%b", edge_node_idx, edge_last, ei, el);
                end
            end
            if (idx_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (idx_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_timeout: got %0d edges pending expected 0", idx_q.size());
            idx_q.delete(); lst_q.delete(); addr_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_leaf();
        int c0;
        hb_mem[3] = 12'h055; hc_mem[3] = 4'd0;
        req_valid = 1'b1; req_node_idx = 10'd3; c0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (leaf !== (cyc == c0 + 2) || hdr_rd_en !== (cyc == c0 + 1) || edge_rd_en !== 1'b0 || edge_valid !== 1'b0) begin
                failures++;
                $display("FAIL leaf_seq: cyc+%0d got leaf=%b hdr=%b erd=%b valid=%b expected leaf=%b hdr=%b erd=0 valid=0",
                         i, leaf, hdr_rd_en, edge_rd_en, edge_valid, (cyc == c0 + 2), (cyc == c0 + 1));
            end
            if (cyc == c0 + 3) begin
                checks++;
                if (req_ready !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL leaf_idle: got ready=%b busy=%b expected 1 0", req_ready, busy);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int k;
        edge_ready = 1'b0;
        req_valid = 1'b1; req_node_idx = 10'd5;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!edge_valid && k < 10) begin @(negedge clk); k++; end
        checks++;
        if (edge_valid !== 1'b1 || edge_node_idx !== 10'd7) begin
            failures++;
            $display("FAIL abort_first_edge: got valid=%b idx=%0d expected 1 7", edge_valid, edge_node_idx);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        edge_ready = 1'b1;
        checks++;
        if (edge_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle: got valid=%b busy=%b ready=%b expected 0 0 1", edge_valid, busy, req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({hdr_rd_en, edge_rd_en, edge_valid, leaf, busy} !== 5'b0) begin
                failures++;
                $display("FAIL abort_quiet: got %b expected 00000", {hdr_rd_en, edge_rd_en, edge_valid, leaf, busy});
            end
        end
        abort = 1'b1; req_valid = 1'b1; req_node_idx = 10'd5;
        @(negedge clk);
        abort = 1'b0; req_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || hdr_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_blocks_req: got busy=%b hdr=%b expected 0 0", busy, hdr_rd_en);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        edge_ready = 1'b1;
        req_valid = 1'b1; req_node_idx = 10'd5;
        repeat (4) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || edge_rd_en !== 1'b0 || edge_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_pre: got busy=%b erd=%b valid=%b expected 1 0 0", busy, edge_rd_en, edge_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, busy, hdr_rd_en, edge_rd_en, edge_valid, edge_last, leaf} !== 7'b1000000
            || edge_node_idx !== '0 || hdr_rd_addr !== '0 || edge_rd_addr !== '0 || stat_edges !== '0) begin
            failures++;
            $display("FAIL rst_mid_async: got ctl=%b idx=%0d haddr=%0h eaddr=%0h stat=%0d expected 1000000 0 0 0 0",
                     {req_ready, busy, hdr_rd_en, edge_rd_en, edge_valid, edge_last, leaf},
                     edge_node_idx, hdr_rd_addr, edge_rd_addr, stat_edges);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (edge_valid !== 1'b0 || leaf !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_quiet: got valid=%b leaf=%b busy=%b expected 0 0 0", edge_valid, leaf, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stats();
        test_wrap();
        test_leaf();
        test_abort();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
